sun_tracker: RTL

Two-axis solar-panel tracker that uses the four directional lux readings (n_lux, e_lux, s_lux, w_lux) published by the sensor-polling controller.
- On each sample tick it compares the east/west and north/south readings.
- When the imbalance exceeds a threshold, it issues a burst of stepper pulses on the azimuth or elevation axis toward the brighter side.
- It then waits a settle interval before accepting the next sample.
- It drives the stepper driver's step/dir pins and respects the end-of-travel limit switches.

---
 rtl/tracker_pkg.sv | 34 +++
 rtl/sun_tracker_step_gen.sv | 71 +++++++
 rtl/sun_tracker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// Shared types and constants for the two-axis sun tracker.
// State encoding, direction polarities, lux snapshot layout and the signed difference helper.
package tracker_pkg;

    localparam int LUX_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        EVAL,
        MOVE_AZ,
        MOVE_EL,
        SETTLE,
        FAULT
    } state_e;

    localparam logic DIR_EAST  = 1'b1;
    localparam logic DIR_WEST  = 1'b0;
    localparam logic DIR_NORTH = 1'b1;
    localparam logic DIR_SOUTH = 1'b0;

    typedef struct packed {
        logic [LUX_W-1:0] n;
        logic [LUX_W-1:0] e;
        logic [LUX_W-1:0] s;
        logic [LUX_W-1:0] w;
    } lux_snap_t;

    // Zero-extend both readings so the difference never overflows.
    function automatic logic signed [LUX_W:0] lux_diff(input logic [LUX_W-1:0] a,
                                                       input logic [LUX_W-1:0] b);
        return $signed({1'b0, a}) - $signed({1'b0, b});
    endfunction

endpackage

// File: rtl/sun_tracker_step_gen.sv
// Step-rate divider plus burst counter, shared by both tracker axes.
// The step output is combinational so an abort suppresses a pulse in the same cycle.
module step_gen #(
    parameter int STEP_DIV   = 1000,
    parameter int STEP_BURST = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    output logic step,
    output logic done
);

    localparam int DIV_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam int CNT_W = $clog2(STEP_BURST + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_BURST - 1);

    logic             active_q, active_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: every signal driven here gets a default first, otherwise a path that skips it infers a latch.
    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        cnt_d    = cnt_q;
        step     = 1'b0;
        done     = 1'b0;

        if (start) begin
            active_d = 1'b1;
            div_d    = '0;
            cnt_d    = '0;
        end else if (abort) begin
            active_d = 1'b0;
            div_d    = '0;
            cnt_d    = '0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                step  = 1'b1;
                div_d = '0;
                if (cnt_q == CNT_LAST) begin
                    done     = 1'b1;
                    active_d = 1'b0;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            div_q    <= '0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/sun_tracker.sv
// Two-axis solar tracker: snapshots four lux readings, steps toward the brighter side,
// settles, and latches into FAULT when both end stops of one axis read high together.
module sun_tracker
    import tracker_pkg::*;
#(
    parameter int STEP_DIV      = 1000,
    parameter int STEP_BURST    = 16,
    parameter int THRESH        = 64,
    parameter int MIN_LUX       = 50,
    parameter int SETTLE_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_tick,
    input  logic [LUX_W-1:0] n_lux,
    input  logic [LUX_W-1:0] e_lux,
    input  logic [LUX_W-1:0] s_lux,
    input  logic [LUX_W-1:0] w_lux,
    input  logic             az_limit_e,
    input  logic             az_limit_w,
    input  logic             el_limit_n,
    input  logic             el_limit_s,
    input  logic             fault_clear,
    output logic             az_step,
    output logic             az_dir,
    output logic             el_step,
    output logic             el_dir,
    output logic             busy,
    output logic             fault
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic signed [LUX_W:0] THRESH_S    = (LUX_W + 1)'(THRESH);
    localparam logic [LUX_W-1:0]      MIN_LUX_V   = LUX_W'(MIN_LUX);
    localparam logic [SET_W-1:0]      SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    lux_snap_t        snap_q, snap_d;
    logic             az_dir_q, az_dir_d;
    logic             el_dir_q, el_dir_d;
    logic [SET_W-1:0] settle_q, settle_d;

    logic                    fault_cond;
    logic                    dark;
    logic signed [LUX_W:0]   dew, dns;
    logic                    target_lim;
    logic                    moving;
    logic                    gen_start, gen_abort, gen_step, gen_done;

    assign fault_cond = (az_limit_e & az_limit_w) | (el_limit_n & el_limit_s);

    assign dew  = lux_diff(snap_q.e, snap_q.w);
    assign dns  = lux_diff(snap_q.n, snap_q.s);
    assign dark = (snap_q.n < MIN_LUX_V) && (snap_q.e < MIN_LUX_V) &&
                  (snap_q.s < MIN_LUX_V) && (snap_q.w < MIN_LUX_V);

    assign moving = (state_q == MOVE_AZ) || (state_q == MOVE_EL);

    always_comb begin
        target_lim = 1'b0;
        if (state_q == MOVE_AZ) begin
            target_lim = (az_dir_q == DIR_EAST) ? az_limit_e : az_limit_w;
        end else if (state_q == MOVE_EL) begin
            target_lim = (el_dir_q == DIR_NORTH) ? el_limit_n : el_limit_s;
        end
    end

    // A tripped stop or wiring fault must kill a pulse in the very cycle it is seen.
    assign gen_abort = !moving || target_lim || fault_cond;

    step_gen #(
        .STEP_DIV  (STEP_DIV),
        .STEP_BURST(STEP_BURST)
    ) u_step_gen (
        .clk  (clk),
        .rst  (rst),
        .start(gen_start),
        .abort(gen_abort),
        .step (gen_step),
        .done (gen_done)
    );

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        az_dir_d  = az_dir_q;
        el_dir_d  = el_dir_q;
        settle_d  = '0;
        gen_start = 1'b0;

        if (fault_cond) begin
            state_d = FAULT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (sample_tick) begin
                        snap_d  = '{n: n_lux, e: e_lux, s: s_lux, w: w_lux};
                        state_d = EVAL;
                    end
                end
                EVAL: begin
                    state_d = IDLE;
                    if (!dark) begin
                        if (dew > THRESH_S && !az_limit_e) begin
                            state_d   = MOVE_AZ;
                            az_dir_d  = DIR_EAST;
                            gen_start = 1'b1;
                        end else if (dew < -THRESH_S && !az_limit_w) begin
                            state_d   = MOVE_AZ;
                            az_dir_d  = DIR_WEST;
                            gen_start = 1'b1;
                        end else if (dns > THRESH_S && !el_limit_n) begin
                            state_d   = MOVE_EL;
                            el_dir_d  = DIR_NORTH;
                            gen_start = 1'b1;
                        end else if (dns < -THRESH_S && !el_limit_s) begin
                            state_d   = MOVE_EL;
                            el_dir_d  = DIR_SOUTH;
                            gen_start = 1'b1;
                        end
                    end
                end
                MOVE_AZ, MOVE_EL: begin
                    if (target_lim || gen_done) begin
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_q == SETTLE_LAST) begin
                        state_d = IDLE;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                FAULT: begin
                    // Any tick arriving with the clear is dropped: IDLE is entered without a snapshot.
                    if (fault_clear) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            snap_q   <= '0;
            az_dir_q <= 1'b0;
            el_dir_q <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            az_dir_q <= az_dir_d;
            el_dir_q <= el_dir_d;
            settle_q <= settle_d;
        end
    end

    assign az_step = (state_q == MOVE_AZ) && gen_step;
    assign el_step = (state_q == MOVE_EL) && gen_step;
    assign az_dir  = az_dir_q;
    assign el_dir  = el_dir_q;
    assign busy    = (state_q != IDLE) && (state_q != FAULT);
    assign fault   = (state_q == FAULT);

endmodule
